// File: rtl/l2_pkg.sv
// Shared widths, FSM state codes and op encoding for the L2 line server.
// Pure declarations: no logic, no latency, no flow control.
// Imported by l2_line_server and l2_line_store.
package l2_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/l2_line_store.sv
// Line storage: DEPTH x LINE_W array with per-line valid bits.
// Sync write, registered read (1 cycle); invalid lines read as zero.
// No backpressure: one access per cycle, clr wipes valid bits and rdata only.
module l2_line_store
  import l2_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  // Line contents survive reset; only the valid bits say whether they mean anything.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= '0;
      rdata <= '0;
    end else begin
      if (we) valid[widx] <= 1'b1;
      if (re) rdata <= valid[ridx] ? mem[ridx] : '0;
    end
  end
endmodule

// File: rtl/l2_line_server.sv
// Memory-side line responder: accepts one read/write, answers with a ready pulse.
// Latency: ready exactly LATENCY cycles after the accepting cycle.
// Backpressure: none accepted while busy; requests held high through RESP are ignored.
module l2_line_server
  import l2_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]        state, state_nxt;
  logic [7:0]        cnt;
  logic              op_q, op_cur;
  logic [IDX_W-1:0]  idx_q, idx_cur;
  logic [LINE_W-1:0] wdata_q, wdata_cur;
  logic              accept, enter_resp;
  logic              addr_unused;

  // Upper address bits alias onto the same line by design.
  assign addr_unused = ^addr[ADDR_W-1:IDX_W];

  assign accept = (state == S_IDLE) && (read || write);

  // With LATENCY==1 the store is hit on the accepting edge, before the latches settle.
  always_comb begin
    op_cur    = (state == S_IDLE) ? (write ? OP_WRITE : OP_READ) : op_q;
    idx_cur   = (state == S_IDLE) ? addr[IDX_W-1:0] : idx_q;
    wdata_cur = (state == S_IDLE) ? wdata : wdata_q;
    state_nxt = state;
    case (state)
      S_IDLE:  if (read || write) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == 8'd1) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP) && !reset;

  l2_line_store #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_store (
    .clk   (clk),
    .clr   (reset),
    .we    (enter_resp && (op_cur == OP_WRITE)),
    .widx  (idx_cur),
    .wdata (wdata_cur),
    .re    (enter_resp && (op_cur == OP_READ)),
    .ridx  (idx_cur),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ready    <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      op_q     <= OP_READ;
      idx_q    <= '0;
      wdata_q  <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == S_RESP);
      busy  <= (state_nxt != S_IDLE);
      if (accept) begin
        op_q    <= op_cur;
        idx_q   <= idx_cur;
        wdata_q <= wdata;
        cnt     <= 8'(LATENCY - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (enter_resp && (op_cur == OP_READ) && (rd_count != 16'hFFFF))
        rd_count <= rd_count + 16'd1;
      if (enter_resp && (op_cur == OP_WRITE) && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_l2_line_server.sv
// Bench for l2_line_server: LATENCY=4 and LATENCY=1 instances against a line/valid array model.
module tb_l2_line_server;
  logic         clk = 1'b0;
  logic         reset;
  logic         rd [2];
  logic         wr [2];
  logic [27:0]  ad [2];
  logic [127:0] wd [2];
  logic [127:0] rdt [2];
  logic         rdy [2];
  logic         bsy [2];
  logic [15:0]  rc [2];
  logic [15:0]  wc [2];

  int checks = 0;
  int failures = 0;

  int           lat [2] = '{4, 1};
  logic [127:0] m_line [2][256];
  bit           m_vld [2][256];
  logic [127:0] e_rdata [2];
  int           e_rd [2];
  int           e_wr [2];

  always #5 clk = ~clk;

  l2_line_server #(.LATENCY(4)) u0 (
    .clk(clk), .reset(reset), .read(rd[0]), .write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
    .rdata(rdt[0]), .ready(rdy[0]), .busy(bsy[0]), .rd_count(rc[0]), .wr_count(wc[0])
  );

  l2_line_server #(.LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .read(rd[1]), .write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
    .rdata(rdt[1]), .ready(rdy[1]), .busy(bsy[1]), .rd_count(rc[1]), .wr_count(wc[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  // Model of one completed transaction, applied when the request is issued.
  task automatic model_op(input int u, input bit is_wr, input logic [27:0] a, input logic [127:0] d);
    int idx = int'(a[7:0]);
    if (is_wr) begin
      m_line[u][idx] = d;
      m_vld[u][idx]  = 1'b1;
      e_wr[u] = sat(e_wr[u]);
    end else begin
      e_rdata[u] = m_vld[u][idx] ? m_line[u][idx] : 128'd0;
      e_rd[u] = sat(e_rd[u]);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 256; i++) m_vld[u][i] = 1'b0;
      e_rdata[u] = '0;
      e_rd[u] = 0;
      e_wr[u] = 0;
    end
  endtask

  task automatic check_outputs(input int u, input string tag);
    chk({tag, "_rdata"}, rdt[u], e_rdata[u]);
    chk({tag, "_rd_count"}, 128'(rc[u]), 128'(e_rd[u]));
    chk({tag, "_wr_count"}, 128'(wc[u]), 128'(e_wr[u]));
  endtask

  // One request: counts cycles to ready, scrambles inputs while waiting, drops after ready.
  task automatic apply(input int u, input bit is_wr, input bit both, input logic [27:0] a,
                       input logic [127:0] d, input string tag);
    int k = 0;
    bit seen = 1'b0;
    @(negedge clk);
    wr[u] = is_wr;
    rd[u] = !is_wr || both;
    ad[u] = a;
    wd[u] = d;
    model_op(u, is_wr, a, d);
    while (!seen && k < lat[u] + 4) begin
      @(negedge clk);
      k++;
      if (rdy[u]) seen = 1'b1;
      else if (k == 1) begin
        chk({tag, "_busy"}, 128'(bsy[u]), 128'(1));
        ad[u] = 28'($urandom);
        wd[u] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk({tag, "_latency"}, 128'(seen ? k : -1), 128'(lat[u]));
    check_outputs(u, tag);
    rd[u] = 1'b0;
    wr[u] = 1'b0;
    @(negedge clk);
    chk({tag, "_one_pulse"}, 128'(rdy[u]), 128'(0));
    chk({tag, "_idle"}, 128'(bsy[u]), 128'(0));
  endtask

  initial begin
    int k;
    int pulses;
    logic [127:0] d;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; ad[u] = '0; wd[u] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_ready", 128'(rdy[u]), 128'(0));
      chk("reset_busy", 128'(bsy[u]), 128'(0));
      check_outputs(u, "reset");
    end

    // Read of never-written line, then write/read round trip.
    apply(0, 1'b0, 1'b0, 28'h0000010, 128'd0, "t1_read");
    d = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    apply(0, 1'b1, 1'b0, 28'h5, d, "t2_write");
    apply(0, 1'b0, 1'b0, 28'h5, 128'd0, "t2_read");

    // Read held through ready is a back-to-back second request.
    @(negedge clk);
    rd[0] = 1'b1; ad[0] = 28'h5;
    model_op(0, 1'b0, 28'h5, 128'd0);
    k = 0;
    while (!rdy[0] && k < 10) begin @(negedge clk); k++; end
    chk("t3_first_latency", 128'(k), 128'(4));
    check_outputs(0, "t3_first");
    model_op(0, 1'b0, 28'h5, 128'd0);
    k = 0;
    do begin @(negedge clk); k++; end while (!rdy[0] && k < 12);
    chk("t3_second_spacing", 128'(k), 128'(5));
    check_outputs(0, "t3_second");
    rd[0] = 1'b0;
    @(negedge clk);
    chk("t3_one_pulse", 128'(rdy[0]), 128'(0));

    // Simultaneous read+write is a write.
    apply(0, 1'b1, 1'b1, 28'h7, 128'hA5A5_0707_0707_0707_0707_0707_0707_5A5A, "t4_both");
    apply(0, 1'b0, 1'b0, 28'h7, 128'd0, "t4_read");

    // Reset in cycle t+2 of a write aborts it and drops all valid bits.
    apply(0, 1'b1, 1'b0, 28'h9, 128'h1234, "t5_prewrite");
    @(negedge clk);
    wr[0] = 1'b1; ad[0] = 28'h9; wd[0] = 128'h9999;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wr[0] = 1'b0;
    pulses = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      if (rdy[0]) pulses++;
      @(negedge clk);
    end
    chk("t5_no_ready", 128'(pulses), 128'(0));
    check_outputs(0, "t5_after_reset");
    apply(0, 1'b0, 1'b0, 28'h9, 128'd0, "t5_read");

    // LATENCY=1 instance, including aliasing and counter saturation.
    apply(1, 1'b1, 1'b0, 28'h0000103, 128'hC0FFEE, "t6_write");
    apply(1, 1'b0, 1'b0, 28'h0000203, 128'd0, "t6_alias_read");
    @(negedge clk);
    u1.rd_count = 16'hFFFE;
    e_rd[1] = 65534;
    for (int i = 0; i < 3; i++) apply(1, 1'b0, 1'b0, 28'(i), 128'd0, "t6_sat");
    chk("t6_sat_final", 128'(rc[1]), 128'h0FFFF);

    // Randomized traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int u = n % 2;
      int op = $urandom_range(0, 2);
      logic [27:0] a = {18'($urandom_range(0, 3)), 2'b00, 8'($urandom_range(0, 15))};
      d = {$urandom, $urandom, $urandom, $urandom};
      apply(u, op != 0, op == 2, a, d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
